// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared light encodings, error codes and monitor states for tlc
package tlc_pkg;

   // Light-state bus encoding shared with the tlc controller
   typedef enum logic [1:0] {
      RED = 2'b00,
      YEL = 2'b01,
      GRN = 2'b10,
      BAD = 2'b11
   } light_t;

   // Monitor FSM states
   typedef enum logic [1:0] {
      SYNC  = 2'b00,
      TRACK = 2'b01,
      ERROR = 2'b10
   } mon_state_t;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_ENC   = 3'd1;
   localparam logic [2:0] ERR_TRANS = 3'd2;
   localparam logic [2:0] ERR_SHORT = 3'd3;
   localparam logic [2:0] ERR_LONG  = 3'd4;

   // Legal successor of a light phase; BAD has no successor
   function automatic light_t next_light(input light_t cur);
      case (cur)
         RED:     return GRN;
         GRN:     return YEL;
         YEL:     return RED;
         default: return BAD;
      endcase
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - dwell counter with per-phase min/max compare
module tlc_phase_timer
   import tlc_pkg::*;
#(
   parameter int RED_MIN = 6,
   parameter int RED_MAX = 6,
   parameter int GRN_MIN = 5,
   parameter int GRN_MAX = 5,
   parameter int YEL_MIN = 5,
   parameter int YEL_MAX = 5,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_clr,
   input  logic             cnt_load,
   input  logic             cnt_inc,
   input  light_t           phase,
   output logic [CNT_W-1:0] dwell,
   output logic             too_short,
   output logic             at_max
);

   logic [CNT_W-1:0] min_sel;
   logic [CNT_W-1:0] max_sel;

   // Bounds of the phase being timed; BAD never bounds anything
   always_comb begin
      min_sel = '0;
      max_sel = '1;
      case (phase)
         RED: begin
            min_sel = CNT_W'(RED_MIN);
            max_sel = CNT_W'(RED_MAX);
         end
         GRN: begin
            min_sel = CNT_W'(GRN_MIN);
            max_sel = CNT_W'(GRN_MAX);
         end
         YEL: begin
            min_sel = CNT_W'(YEL_MIN);
            max_sel = CNT_W'(YEL_MAX);
         end
         default: begin
            min_sel = '0;
            max_sel = '1;
         end
      endcase
   end

   assign too_short = (dwell < min_sel);
   assign at_max    = (dwell == max_sel);

   // Dwell counter: clear beats load beats saturating increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell <= '0;
      end else if (cnt_clr) begin
         dwell <= '0;
      end else if (cnt_load) begin
         dwell <= CNT_W'(1);
      end else if (cnt_inc && (dwell != '1)) begin
         dwell <= dwell + 1'b1;
      end
   end

endmodule

// File: rtl/tlc_monitor.sv
// rtl/tlc_monitor.sv - light-sequence and dwell-time observer for tlc
module tlc_monitor
   import tlc_pkg::*;
#(
   parameter int RED_MIN = 6,
   parameter int RED_MAX = 6,
   parameter int GRN_MIN = 5,
   parameter int GRN_MAX = 5,
   parameter int YEL_MIN = 5,
   parameter int YEL_MAX = 5,
   parameter int CNT_W   = 8,
   parameter int CYC_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       light,
   output logic             locked,
   output logic [CNT_W-1:0] dwell,
   output logic [CYC_W-1:0] cycles,
   output logic             phase_done,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [1:0]       err_phase
);

   mon_state_t       state, state_n;
   light_t           prev_light;
   logic             locked_n, phase_done_n, err_n;
   logic [2:0]       err_code_n;
   logic [1:0]       err_phase_n;
   logic [CYC_W-1:0] cycles_n;
   logic             cnt_clr, cnt_load, cnt_inc;
   logic             too_short, at_max;
   logic             changed;

   tlc_phase_timer #(
      .RED_MIN (RED_MIN),
      .RED_MAX (RED_MAX),
      .GRN_MIN (GRN_MIN),
      .GRN_MAX (GRN_MAX),
      .YEL_MIN (YEL_MIN),
      .YEL_MAX (YEL_MAX),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .cnt_clr   (cnt_clr),
      .cnt_load  (cnt_load),
      .cnt_inc   (cnt_inc),
      .phase     (prev_light),
      .dwell     (dwell),
      .too_short (too_short),
      .at_max    (at_max)
   );

   assign changed = (light != prev_light);

   // Previous sample, tracked only while the monitor is enabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_light <= RED;
      end else if (en) begin
         prev_light <= light_t'(light);
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= SYNC;
         locked     <= 1'b0;
         phase_done <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         err_phase  <= 2'b00;
         cycles     <= '0;
      end else begin
         state      <= state_n;
         locked     <= locked_n;
         phase_done <= phase_done_n;
         err        <= err_n;
         err_code   <= err_code_n;
         err_phase  <= err_phase_n;
         cycles     <= cycles_n;
      end
   end

   // Next state and outputs: clr, then enable, then per-state checks in priority order
   always_comb begin
      state_n      = state;
      locked_n     = 1'b0;
      phase_done_n = 1'b0;
      err_n        = err;
      err_code_n   = err_code;
      err_phase_n  = err_phase;
      cycles_n     = cycles;
      cnt_clr      = 1'b0;
      cnt_load     = 1'b0;
      cnt_inc      = 1'b0;
      if (clr) begin
         state_n     = SYNC;
         err_n       = 1'b0;
         err_code_n  = ERR_NONE;
         err_phase_n = 2'b00;
         cycles_n    = '0;
         cnt_clr     = 1'b1;
      end else if (!en) begin
         state_n = SYNC;
         cnt_clr = 1'b1;
      end else begin
         case (state)
            SYNC: begin
               if (light == BAD) begin
                  state_n     = ERROR;
                  err_n       = 1'b1;
                  err_code_n  = ERR_ENC;
                  err_phase_n = light;
               end else if ((prev_light == RED) && (light == GRN)) begin
                  state_n  = TRACK;
                  locked_n = 1'b1;
                  cnt_load = 1'b1;
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            TRACK: begin
               if (light == BAD) begin
                  state_n     = ERROR;
                  err_n       = 1'b1;
                  err_code_n  = ERR_ENC;
                  err_phase_n = light;
               end else if (changed && (light != next_light(prev_light))) begin
                  state_n     = ERROR;
                  err_n       = 1'b1;
                  err_code_n  = ERR_TRANS;
                  err_phase_n = prev_light;
               end else if (changed && too_short) begin
                  state_n     = ERROR;
                  err_n       = 1'b1;
                  err_code_n  = ERR_SHORT;
                  err_phase_n = prev_light;
               end else if (!changed && at_max) begin
                  state_n     = ERROR;
                  err_n       = 1'b1;
                  err_code_n  = ERR_LONG;
                  err_phase_n = light;
               end else if (changed) begin
                  locked_n     = 1'b1;
                  phase_done_n = 1'b1;
                  cnt_load     = 1'b1;
                  if (prev_light == YEL) begin
                     cycles_n = cycles + 1'b1;
                  end
               end else begin
                  locked_n = 1'b1;
                  cnt_inc  = 1'b1;
               end
            end
            default: begin
               state_n = ERROR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlc_monitor.sv
// tb/tb_tlc_monitor.sv - scoreboard bench for tlc_monitor
module tb_tlc_monitor;

   localparam logic [1:0] L_RED = 2'b00;
   localparam logic [1:0] L_YEL = 2'b01;
   localparam logic [1:0] L_GRN = 2'b10;
   localparam logic [1:0] L_BAD = 2'b11;

   logic        clk;
   logic        rst;
   logic        en;
   logic        clr;
   logic [1:0]  light;
   logic        locked;
   logic [7:0]  dwell;
   logic [15:0] cycles;
   logic        phase_done;
   logic        err;
   logic [2:0]  err_code;
   logic [1:0]  err_phase;

   typedef struct {
      int kind;
      int code;
      int ph;
      bit chk_ph;
      int dw;
      int cyc;
   } ev_t;

   ev_t q[$];
   int  checks;
   int  errors;
   logic err_q;

   tlc_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .light      (light),
      .locked     (locked),
      .dwell      (dwell),
      .cycles     (cycles),
      .phase_done (phase_done),
      .err        (err),
      .err_code   (err_code),
      .err_phase  (err_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] l, input int n);
      light = l;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_pd(input int cyc);
      ev_t e;
      e.kind = 0; e.code = 0; e.ph = 0; e.chk_ph = 1'b0; e.dw = 1; e.cyc = cyc;
      q.push_back(e);
   endtask

   task automatic exp_err(input int code, input int ph, input bit chk_ph, input int dw, input int cyc);
      ev_t e;
      e.kind = 1; e.code = code; e.ph = ph; e.chk_ph = chk_ph; e.dw = dw; e.cyc = cyc;
      q.push_back(e);
   endtask

   // Monitor: pops one expectation whenever the DUT reports a phase end or a new error
   initial begin
      err_q = 1'b0;
      forever begin
         @(negedge clk);
         if (phase_done || (err && !err_q)) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_event phase_done=%0d err=%0d code=%0d", phase_done, err, err_code);
            end else begin
               ev_t e;
               e = q.pop_front();
               if (e.kind == 0) begin
                  chk("ev_phase_done", int'(phase_done), 1);
                  chk("ev_pd_dwell", int'(dwell), e.dw);
                  chk("ev_pd_cycles", int'(cycles), e.cyc);
                  chk("ev_pd_err", int'(err), 0);
               end else begin
                  chk("ev_err_flag", int'(err), 1);
                  chk("ev_err_code", int'(err_code), e.code);
                  if (e.chk_ph) chk("ev_err_phase", int'(err_phase), e.ph);
                  chk("ev_err_dwell", int'(dwell), e.dw);
                  chk("ev_err_cycles", int'(cycles), e.cyc);
                  chk("ev_err_pd", int'(phase_done), 0);
               end
            end
         end
         err_q = err;
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0; en = 1'b1; clr = 1'b0; light = L_RED;
      step(L_RED, 3);
      chk("rst_locked", int'(locked), 0);
      chk("rst_dwell", int'(dwell), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_cycles", int'(cycles), 0);
      rst = 1'b1;
      step(L_RED, 20);
      chk("sync_locked", int'(locked), 0);
      chk("sync_dwell", int'(dwell), 0);
      chk("sync_err", int'(err), 0);
      chk("sync_cycles", int'(cycles), 0);

      // Nominal: lock then three full cycles
      step(L_GRN, 1);
      chk("lock_locked", int'(locked), 1);
      chk("lock_dwell", int'(dwell), 1);
      for (int i = 0; i < 3; i++) begin
         step(L_GRN, 4);
         exp_pd(i);
         step(L_YEL, 5);
         exp_pd(i + 1);
         step(L_RED, 6);
         exp_pd(i + 1);
         step(L_GRN, 1);
      end
      chk("nom_cycles", int'(cycles), 3);
      chk("nom_err", int'(err), 0);
      chk("nom_locked", int'(locked), 1);

      // Short YEL
      step(L_GRN, 4);
      exp_pd(3);
      step(L_YEL, 3);
      exp_err(3, 1, 1'b1, 3, 3);
      step(L_RED, 1);
      chk("short_locked", int'(locked), 0);
      step(L_GRN, 2);
      chk("short_frozen_code", int'(err_code), 3);
      chk("short_frozen_cycles", int'(cycles), 3);

      clr = 1'b1;
      step(L_RED, 1);
      clr = 1'b0;
      chk("clr_err", int'(err), 0);
      chk("clr_code", int'(err_code), 0);
      chk("clr_phase", int'(err_phase), 0);
      chk("clr_cycles", int'(cycles), 0);
      chk("clr_dwell", int'(dwell), 0);

      // Long GRN: flagged on the 6th GRN sample
      step(L_GRN, 1);
      exp_err(4, 2, 1'b1, 5, 0);
      step(L_GRN, 5);
      chk("long_locked", int'(locked), 0);
      clr = 1'b1;
      step(L_RED, 1);
      clr = 1'b0;

      // Illegal GRN->RED
      step(L_GRN, 3);
      exp_err(2, 2, 1'b1, 3, 0);
      step(L_RED, 1);
      clr = 1'b1;
      step(L_RED, 1);
      clr = 1'b0;

      // Bad encoding after relock
      step(L_GRN, 1);
      exp_err(1, 0, 1'b0, 1, 0);
      step(L_BAD, 1);
      clr = 1'b1;
      step(L_RED, 1);
      clr = 1'b0;

      // clr wins over a same-edge encoding error
      step(L_GRN, 1);
      chk("prio_locked_before", int'(locked), 1);
      clr = 1'b1;
      step(L_BAD, 1);
      clr = 1'b0;
      chk("prio_err", int'(err), 0);
      chk("prio_locked", int'(locked), 0);
      chk("prio_code", int'(err_code), 0);

      // Relock, one cycle, then disable mid-GRN
      step(L_RED, 1);
      step(L_GRN, 1);
      chk("relock_locked", int'(locked), 1);
      chk("relock_dwell", int'(dwell), 1);
      step(L_GRN, 4);
      exp_pd(0);
      step(L_YEL, 5);
      exp_pd(1);
      step(L_RED, 6);
      exp_pd(1);
      step(L_GRN, 3);
      en = 1'b0;
      step(L_GRN, 3);
      chk("dis_locked", int'(locked), 0);
      chk("dis_dwell", int'(dwell), 0);
      chk("dis_cycles", int'(cycles), 1);
      chk("dis_err", int'(err), 0);
      en = 1'b1;
      step(L_GRN, 2);
      chk("reen_nolock", int'(locked), 0);
      step(L_RED, 3);
      step(L_GRN, 1);
      chk("reen_locked", int'(locked), 1);
      chk("reen_dwell", int'(dwell), 1);
      chk("reen_cycles", int'(cycles), 1);
      step(L_GRN, 2);
      chk("queue_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
